// File: rtl/spi_resp_packer.sv
// Purpose: frames one CCU response as SOF, opcode, N, N payload bytes, XOR checksum onto an AXI4-Stream byte link.
// Latency: the SOF byte is valid one clock after request acceptance; one byte per cycle afterwards when unstalled.
// Backpressure: single registered output stage holds data while axis_rready is low; payload is pulled only into a free slot.
//
// Ports:
//   axi_aclk, axi_aresetn         clock, asynchronous active-low reset
//   req_valid/req_ready           response request handshake; req_opcode/req_len captured on acceptance
//   pld_data/pld_valid/pld_ready  payload byte stream, consumed only while emitting payload
//   axis_rdata/rvalid/rready/rlast  framed byte stream; rlast marks the checksum byte
//   busy                          high from acceptance until the checksum handshake
//   len_err                       one-cycle pulse when a request is rejected for req_len > MAX_LEN
module spi_resp_packer #(
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN  = 64
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_opcode,
  input  logic [7:0] req_len,
  input  logic [7:0] pld_data,
  input  logic       pld_valid,
  output logic       pld_ready,
  output logic [7:0] axis_rdata,
  output logic       axis_rvalid,
  input  logic       axis_rready,
  output logic       axis_rlast,
  output logic       busy,
  output logic       len_err
);

  typedef enum logic [2:0] {IDLE, SOF, OPC, LEN, PLD, CSUM} state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t     state, state_nxt;
  logic [7:0] opc_q, opc_nxt;
  logic [7:0] len_q, len_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [7:0] csum_q, csum_nxt;

  logic       slot_free;
  logic       len_ok;
  logic       ld;
  logic [7:0] ld_dat;
  logic       ld_last;

  // The output register can take a new byte when empty or when its byte is leaving this cycle.
  assign slot_free = !axis_rvalid || axis_rready;
  assign len_ok    = ({1'b0, req_len} <= MAX_LEN_W);

  always_comb begin
    state_nxt = state;
    opc_nxt   = opc_q;
    len_nxt   = len_q;
    cnt_nxt   = cnt_q;
    csum_nxt  = csum_q;
    ld        = 1'b0;
    ld_dat    = 8'h00;
    ld_last   = 1'b0;
    pld_ready = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready && len_ok) begin
          state_nxt = SOF;
          opc_nxt   = req_opcode;
          len_nxt   = req_len;
          cnt_nxt   = 8'h00;
          csum_nxt  = 8'h00;
        end
      end
      SOF: begin
        if (slot_free) begin
          ld        = 1'b1;
          ld_dat    = SOF_BYTE;
          state_nxt = OPC;
        end
      end
      OPC: begin
        if (slot_free) begin
          ld        = 1'b1;
          ld_dat    = opc_q;
          csum_nxt  = csum_q ^ opc_q;
          state_nxt = LEN;
        end
      end
      LEN: begin
        if (slot_free) begin
          ld        = 1'b1;
          ld_dat    = len_q;
          csum_nxt  = csum_q ^ len_q;
          state_nxt = (len_q != 8'h00) ? PLD : CSUM;
        end
      end
      PLD: begin
        // cnt never passes len_q, so N=255 cannot wrap the 8-bit counter.
        pld_ready = slot_free && (cnt_q < len_q);
        if (pld_valid && pld_ready) begin
          ld       = 1'b1;
          ld_dat   = pld_data;
          csum_nxt = csum_q ^ pld_data;
          cnt_nxt  = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) begin
            state_nxt = CSUM;
          end
        end
      end
      CSUM: begin
        // The last payload byte may still be waiting in the output register;
        // the checksum goes in behind it, then we wait for its own handshake.
        if (axis_rvalid && axis_rlast) begin
          if (axis_rready) begin
            state_nxt = IDLE;
          end
        end else if (slot_free) begin
          ld      = 1'b1;
          ld_dat  = csum_q;
          ld_last = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= IDLE;
      opc_q     <= 8'h00;
      len_q     <= 8'h00;
      cnt_q     <= 8'h00;
      csum_q    <= 8'h00;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      opc_q     <= opc_nxt;
      len_q     <= len_nxt;
      cnt_q     <= cnt_nxt;
      csum_q    <= csum_nxt;
      req_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      len_err   <= (state == IDLE) && req_valid && req_ready && !len_ok;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      axis_rvalid <= 1'b0;
      axis_rdata  <= 8'h00;
      axis_rlast  <= 1'b0;
    end else if (ld) begin
      axis_rvalid <= 1'b1;
      axis_rdata  <= ld_dat;
      axis_rlast  <= ld_last;
    end else if (axis_rready) begin
      axis_rvalid <= 1'b0;
      axis_rlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_resp_packer.sv
// Purpose: directed self-checking bench for spi_resp_packer framing, flow control, length reject and reset.
// Latency: checks SOF one clock after acceptance and the single idle cycle between back-to-back packets.
// Backpressure: exercises toggling axis_rready and gapped pld_valid; verifies held output bytes stay stable.
module tb_spi_resp_packer;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_opcode;
  logic [7:0] req_len;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] axis_rdata;
  logic       axis_rvalid;
  logic       axis_rready;
  logic       axis_rlast;
  logic       busy;
  logic       len_err;

  spi_resp_packer #(.SOF_BYTE(8'hA5), .MAX_LEN(64)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_len     (req_len),
    .pld_data    (pld_data),
    .pld_valid   (pld_valid),
    .pld_ready   (pld_ready),
    .axis_rdata  (axis_rdata),
    .axis_rvalid (axis_rvalid),
    .axis_rready (axis_rready),
    .axis_rlast  (axis_rlast),
    .busy        (busy),
    .len_err     (len_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pld_q[$];
  logic [8:0] out_q[$];   // {rlast, rdata}
  logic [8:0] exp_q[$];

  logic       tog = 1'b0;
  logic       gap = 1'b0;
  logic       pld_seen = 1'b0;
  logic       hold_prev = 1'b0;
  logic [8:0] held = 9'h000;
  logic       pf;
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Payload source, output sink and hold-stability monitor.
  always begin
    @(negedge axi_aclk);
    pf = pld_valid && pld_ready;
    if (axi_aresetn) begin
      if (hold_prev) begin
        chk("hold_vld", 32'(axis_rvalid), 32'd1);
        chk("hold_dat", 32'({axis_rlast, axis_rdata}), 32'(held));
      end
      if (axis_rvalid && axis_rready) out_q.push_back({axis_rlast, axis_rdata});
      hold_prev = axis_rvalid && !axis_rready;
      held      = {axis_rlast, axis_rdata};
      if (pld_ready) pld_seen = 1'b1;
    end else begin
      hold_prev = 1'b0;
    end
    cyc++;
    @(posedge axi_aclk);
    #1;
    if (pf && pld_q.size() != 0) void'(pld_q.pop_front());
    axis_rready = tog ? ~axis_rready : 1'b1;
    pld_valid   = (pld_q.size() != 0) && !(gap && (cyc % 3 == 1));
    pld_data    = (pld_q.size() != 0) ? pld_q[0] : 8'h00;
  end

  task automatic send_req(input logic [7:0] opc, input logic [7:0] len);
    @(posedge axi_aclk);
    #1;
    req_valid  = 1'b1;
    req_opcode = opc;
    req_len    = len;
    for (int k = 0; k < 50; k++) begin
      @(negedge axi_aclk);
      if (req_ready) break;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge axi_aclk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_pkt(input string tag, input int n);
    for (int k = 0; k < 500; k++) begin
      @(negedge axi_aclk);
      if (out_q.size() >= n) break;
    end
    chk($sformatf("%s_nbytes", tag), 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n && i < out_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    logic rv;
    axi_aresetn = 1'b0;
    req_valid   = 1'b0;
    req_opcode  = 8'h00;
    req_len     = 8'h00;
    pld_data    = 8'h00;
    pld_valid   = 1'b0;
    axis_rready = 1'b1;

    // Reset state
    @(negedge axi_aclk);
    chk("rst_outputs", 32'({req_ready, pld_ready, axis_rvalid, axis_rlast, busy, len_err, axis_rdata}), 32'd0);
    @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    repeat (2) @(negedge axi_aclk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Basic packet: A5 10 03 01 02 03 13
    pld_q = '{8'h01, 8'h02, 8'h03};
    send_req(8'h10, 8'd3);
    @(negedge axi_aclk);
    chk("t1_busy_after_acc", 32'(busy), 32'd1);
    chk("t1_rvalid_acc_cycle", 32'(axis_rvalid), 32'd0);
    @(negedge axi_aclk);
    chk("t1_sof_valid", 32'(axis_rvalid), 32'd1);
    chk("t1_sof_data", 32'(axis_rdata), 32'hA5);
    exp_q = '{9'h0A5, 9'h010, 9'h003, 9'h001, 9'h002, 9'h003, 9'h113};
    wait_pkt("t1", 7);
    @(negedge axi_aclk);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // Zero-length packet: A5 22 00 22
    pld_seen = 1'b0;
    send_req(8'h22, 8'd0);
    exp_q = '{9'h0A5, 9'h022, 9'h000, 9'h122};
    wait_pkt("t2", 4);
    chk("t2_pld_ready_seen", 32'(pld_seen), 32'd0);

    // Length reject: 65 > 64
    @(posedge axi_aclk);
    #1;
    req_valid  = 1'b1;
    req_opcode = 8'h77;
    req_len    = 8'd65;
    @(negedge axi_aclk);
    chk("t3_req_ready", 32'(req_ready), 32'd1);
    @(posedge axi_aclk);
    #1 req_valid = 1'b0;
    @(negedge axi_aclk);
    chk("t3_len_err", 32'(len_err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    errs = 0;
    rv   = axis_rvalid;
    for (int k = 0; k < 6; k++) begin
      @(negedge axi_aclk);
      errs += int'(len_err);
      rv   |= axis_rvalid | busy;
    end
    chk("t3_len_err_width", 32'(errs), 32'd0);
    chk("t3_no_output", 32'(rv), 32'd0);
    chk("t3_no_bytes", 32'(out_q.size()), 32'd0);

    // Backpressure and payload gaps: csum = 5A^04^AA^BB^CC^DD = 5E
    tog   = 1'b1;
    gap   = 1'b1;
    pld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_req(8'h5A, 8'd4);
    exp_q = '{9'h0A5, 9'h05A, 9'h004, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h15E};
    wait_pkt("t4", 8);
    tog = 1'b0;
    gap = 1'b0;
    repeat (3) @(negedge axi_aclk);

    // Reset in the middle of a len=8 packet
    pld_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_req(8'h01, 8'd8);
    for (int k = 0; k < 100; k++) begin
      @(negedge axi_aclk);
      if (out_q.size() >= 4) break;
    end
    chk("t5_reached_payload", 32'(out_q.size() >= 4), 32'd1);
    #1 axi_aresetn = 1'b0;
    #1;
    chk("t5_rst_outputs", 32'({req_ready, pld_ready, axis_rvalid, axis_rlast, busy, len_err, axis_rdata}), 32'd0);
    repeat (2) @(negedge axi_aclk);
    pld_q.delete();
    out_q.delete();
    @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    repeat (2) @(negedge axi_aclk);
    chk("t5_idle_req_ready", 32'(req_ready), 32'd1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge axi_aclk);
    chk("t5_no_resume", 32'(out_q.size()), 32'd0);
    // csum = 33^01^7E = 4C
    pld_q = '{8'h7E};
    send_req(8'h33, 8'd1);
    exp_q = '{9'h0A5, 9'h033, 9'h001, 9'h07E, 9'h14C};
    wait_pkt("t5", 5);

    // Back-to-back requests with req_valid held
    pld_q = '{8'h01, 8'h10, 8'h20};
    @(posedge axi_aclk);
    #1;
    req_valid  = 1'b1;
    req_opcode = 8'h41;
    req_len    = 8'd1;
    for (int k = 0; k < 50; k++) begin
      @(negedge axi_aclk);
      if (req_ready) break;
    end
    chk("t6_first_acc", 32'(req_ready), 32'd1);
    @(posedge axi_aclk);
    #1;
    req_opcode = 8'h42;
    req_len    = 8'd2;
    for (int k = 0; k < 100; k++) begin
      @(negedge axi_aclk);
      if (axis_rvalid && axis_rready && axis_rlast) break;
    end
    chk("t6_first_last", 32'(axis_rvalid && axis_rlast), 32'd1);
    @(negedge axi_aclk);
    chk("t6_gap_idle", 32'({busy, axis_rvalid, req_ready}), 32'b001);
    @(posedge axi_aclk);
    #1 req_valid = 1'b0;
    @(negedge axi_aclk);
    chk("t6_second_acc", 32'({busy, axis_rvalid}), 32'b10);
    @(negedge axi_aclk);
    chk("t6_second_sof", 32'({axis_rvalid, axis_rdata}), 32'h1A5);
    exp_q = '{9'h0A5, 9'h041, 9'h001, 9'h001, 9'h141,
              9'h0A5, 9'h042, 9'h002, 9'h010, 9'h020, 9'h170};
    wait_pkt("t6", 11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
